lpf_interp: RTL and testbench

- Interpolating low-pass stage: accepts signed audio samples at a low rate (e.g. 48 kHz) through a valid/ready handshake.
- Produces a linearly ramped, smoothed output stream at the CE rate (e.g. 3.58 MHz), RATIO output steps per input sample.
- Upsampling counterpart of the 72:1 integrate-and-dump low-pass decimator.
- Sits between sample-rate audio sources and chip-rate mixers/DACs.

---
 rtl/lpf_interp_if.sv | 24 ++
 rtl/lpf_interp.sv | 128 ++++++++++++
 tb/tb_lpf_interp.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/lpf_interp_if.sv
// Sample-side handshake and output-side strobe bundle of the interpolating low-pass stage.
// The master side drives samples and the CE tick; the slave side is the interpolator.
interface lpf_interp_if #(
  parameter int MSB = 15
) ();
  logic              CE;
  logic              ENABLE;
  logic signed [MSB:0] IDATA;
  logic              IVALID;
  logic              IREADY;
  logic signed [MSB:0] ODATA;
  logic              OSTB;
  logic              UFLOW;

  modport master (
    output CE, ENABLE, IDATA, IVALID,
    input  IREADY, ODATA, OSTB, UFLOW
  );

  modport slave (
    input  CE, ENABLE, IDATA, IVALID,
    output IREADY, ODATA, OSTB, UFLOW
  );
endinterface

// File: rtl/lpf_interp.sv
// Interpolating low-pass stage: 2-entry sample FIFO feeding a linear ramp that walks
// from the previous target to the next one in RATIO CE steps.
module lpf_interp #(
  parameter int MSB   = 15,
  parameter int RATIO = 72,
  parameter int FRAC  = 16
) (
  input  logic         CLK,
  input  logic         RESET,
  lpf_interp_if.slave  io
);
  localparam int ACC_W = MSB + FRAC + 3;
  localparam int PW    = $clog2(RATIO);
  localparam int unsigned RECIP_I = ((32'd1 << FRAC) + RATIO / 2) / RATIO;
  localparam logic [FRAC:0] RECIP = RECIP_I[FRAC:0];
  localparam logic [PW-1:0] LAST  = PW'(RATIO - 1);

  logic [PW-1:0]          phase_q, phase_d;
  logic signed [MSB:0]    cur_q, cur_d;
  logic signed [ACC_W-1:0] step_q, step_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [1:0]             count_q, count_d;
  logic                   wr_ptr_q, wr_ptr_d;
  logic                   rd_ptr_q, rd_ptr_d;
  logic signed [MSB:0]    odata_q, odata_d;
  logic                   ostb_q, ostb_d;
  logic                   uflow_q, uflow_d;

  logic                   ready;
  logic                   push;
  logic                   pop;
  logic signed [MSB:0]    head;
  logic signed [MSB+1:0]  diff;
  logic signed [ACC_W-1:0] diff_ext;
  logic signed [ACC_W-1:0] recip_ext;
  logic signed [ACC_W-1:0] cur_ext;

  assign ready = (count_q != 2'd2) && !RESET;
  assign push  = io.IVALID && ready;
  assign pop   = io.CE && (phase_q == LAST) && (count_q != 2'd0);

  // FIFO storage: each slot loads only when the write pointer selects it.
  for (genvar gi = 0; gi < 2; gi++) begin : g_ent
    logic signed [MSB:0] ent_q, ent_d;

    always_comb begin
      ent_d = ent_q;
      if (push && (wr_ptr_q == 1'(gi))) begin
        ent_d = io.IDATA;
      end
    end

    always_ff @(posedge CLK) begin
      ent_q <= ent_d;
    end
  end

  assign head      = rd_ptr_q ? g_ent[1].ent_q : g_ent[0].ent_q;
  assign diff      = {head[MSB], head} - {cur_q[MSB], cur_q};
  assign diff_ext  = {{(ACC_W-MSB-2){diff[MSB+1]}}, diff};
  assign recip_ext = {{(ACC_W-FRAC-1){1'b0}}, RECIP};
  assign cur_ext   = {{(FRAC+2){cur_q[MSB]}}, cur_q};

  always_comb begin
    phase_d  = phase_q;
    cur_d    = cur_q;
    step_d   = step_q;
    acc_d    = acc_q;
    odata_d  = odata_q;
    ostb_d   = 1'b0;
    uflow_d  = 1'b0;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d  = count_q + {1'b0, push} - {1'b0, pop};

    if (io.CE) begin
      if (phase_q == LAST) begin
        // The outgoing target is the new ramp origin, so the ramp restarts exactly on it
        // and no rounding error survives a frame boundary.
        phase_d = '0;
        acc_d   = cur_ext << FRAC;
        if (pop) begin
          cur_d  = head;
          step_d = diff_ext * recip_ext;
        end else begin
          step_d  = '0;
          uflow_d = 1'b1;
        end
      end else begin
        phase_d = phase_q + PW'(1);
        acc_d   = acc_q + step_q;
      end
      odata_d = io.ENABLE ? acc_d[MSB+FRAC:FRAC] : cur_d;
      ostb_d  = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      phase_q  <= LAST;
      cur_q    <= '0;
      step_q   <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      odata_q  <= '0;
      ostb_q   <= 1'b0;
      uflow_q  <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      cur_q    <= cur_d;
      step_q   <= step_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      odata_q  <= odata_d;
      ostb_q   <= ostb_d;
      uflow_q  <= uflow_d;
    end
  end

  assign io.IREADY = ready;
  assign io.ODATA  = odata_q;
  assign io.OSTB   = ostb_q;
  assign io.UFLOW  = uflow_q;
endmodule

// File: tb/tb_lpf_interp.sv
// Bench for lpf_interp: vector table on a RATIO=4 instance with an ODATA scoreboard,
// plus a hand sequence on a RATIO=72 instance for the long-ramp and floor corners.
module tb_lpf_interp;
  logic clk;
  logic rst_a;
  logic rst_b;
  int   n_checks;
  int   n_errors;

  lpf_interp_if #(.MSB(15)) a_if ();
  lpf_interp_if #(.MSB(15)) b_if ();

  lpf_interp #(.MSB(15), .RATIO(4), .FRAC(16)) dut_a (
    .CLK   (clk),
    .RESET (rst_a),
    .io    (a_if.slave)
  );

  lpf_interp #(.MSB(15), .RATIO(72), .FRAC(16)) dut_b (
    .CLK   (clk),
    .RESET (rst_b),
    .io    (b_if.slave)
  );

  typedef struct {
    bit rst;
    bit ce;
    bit en;
    bit vld;
    int din;
    bit exp_rdy;
    bit exp_uf;
    int exp_od;
  } vec_t;

  vec_t tbl[$];
  int   exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit rst, bit ce, bit en, bit vld, int din,
                              bit rdy, bit uf, int od);
    vec_t v;
    v.rst = rst; v.ce = ce; v.en = en; v.vld = vld; v.din = din;
    v.exp_rdy = rdy; v.exp_uf = uf; v.exp_od = od;
    return v;
  endfunction

  // Scoreboard side: every strobe on the RATIO=4 instance must match the next queued value.
  always @(negedge clk) begin
    int e;
    if (a_if.OSTB) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL a_ostb_unexpected: got strobe with ODATA %0d, expected none", a_if.ODATA);
      end else begin
        e = exp_q.pop_front();
        check("a_odata", a_if.ODATA, e);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int od;
    n_checks = 0;
    n_errors = 0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    a_if.CE = 1'b0; a_if.ENABLE = 1'b1; a_if.IVALID = 1'b0; a_if.IDATA = '0;
    b_if.CE = 1'b0; b_if.ENABLE = 1'b1; b_if.IVALID = 1'b0; b_if.IDATA = '0;

    //            rst ce en vld  din    rdy uf  od
    tbl.push_back(mk(1, 0, 1, 0,     0,  0, 0,     0));
    tbl.push_back(mk(1, 0, 1, 0,     0,  0, 0,     0));
    tbl.push_back(mk(0, 0, 1, 1,   400,  1, 0,     0));
    tbl.push_back(mk(0, 0, 1, 0,     0,  1, 0,     0));
    tbl.push_back(mk(0, 0, 1, 0,     0,  1, 0,     0));
    tbl.push_back(mk(0, 1, 1, 0,     0,  1, 0,     0));
    tbl.push_back(mk(0, 0, 1, 0,     0,  1, 0,     0));
    tbl.push_back(mk(0, 0, 1, 0,     0,  1, 0,     0));
    tbl.push_back(mk(0, 1, 1, 0,     0,  1, 0,   100));
    tbl.push_back(mk(0, 0, 1, 0,     0,  1, 0,     0));
    tbl.push_back(mk(0, 0, 1, 0,     0,  1, 0,     0));
    tbl.push_back(mk(0, 1, 1, 0,     0,  1, 0,   200));
    tbl.push_back(mk(0, 0, 1, 0,     0,  1, 0,     0));
    tbl.push_back(mk(0, 0, 1, 0,     0,  1, 0,     0));
    tbl.push_back(mk(0, 1, 1, 0,     0,  1, 0,   300));
    tbl.push_back(mk(0, 0, 1, 1,  -400,  1, 0,     0));
    tbl.push_back(mk(0, 1, 1, 1,   500,  1, 0,   400));
    tbl.push_back(mk(0, 1, 1, 0,     0,  1, 0,   200));
    tbl.push_back(mk(0, 1, 1, 0,     0,  1, 0,     0));
    tbl.push_back(mk(0, 1, 1, 0,     0,  1, 0,  -200));
    tbl.push_back(mk(0, 1, 1, 0,     0,  1, 0,  -400));
    tbl.push_back(mk(0, 1, 1, 0,     0,  1, 0,  -175));
    tbl.push_back(mk(0, 1, 1, 0,     0,  1, 0,    50));
    tbl.push_back(mk(0, 1, 1, 0,     0,  1, 0,   275));
    tbl.push_back(mk(0, 1, 1, 0,     0,  1, 1,   500));
    tbl.push_back(mk(0, 1, 1, 0,     0,  1, 0,   500));
    tbl.push_back(mk(0, 1, 1, 0,     0,  1, 0,   500));
    tbl.push_back(mk(0, 1, 1, 0,     0,  1, 0,   500));
    tbl.push_back(mk(0, 1, 1, 0,     0,  1, 1,   500));
    tbl.push_back(mk(0, 0, 1, 1,  1000,  1, 0,     0));
    tbl.push_back(mk(0, 0, 1, 1,  2000,  1, 0,     0));
    tbl.push_back(mk(0, 0, 1, 1,  3000,  0, 0,     0));
    tbl.push_back(mk(0, 1, 1, 1,  3000,  0, 0,   500));
    tbl.push_back(mk(0, 1, 1, 1,  3000,  0, 0,   500));
    tbl.push_back(mk(0, 1, 1, 1,  3000,  0, 0,   500));
    tbl.push_back(mk(0, 1, 1, 1,  3000,  0, 0,   500));
    tbl.push_back(mk(0, 1, 1, 1,  3000,  1, 0,   625));
    tbl.push_back(mk(0, 1, 1, 0,     0,  0, 0,   750));
    tbl.push_back(mk(0, 1, 1, 0,     0,  0, 0,   875));
    tbl.push_back(mk(0, 1, 1, 0,     0,  0, 0,  1000));
    tbl.push_back(mk(0, 1, 1, 0,     0,  1, 0,  1250));
    tbl.push_back(mk(0, 0, 1, 1, -3000,  1, 0,     0));
    tbl.push_back(mk(0, 0, 1, 0,     0,  0, 0,     0));
    tbl.push_back(mk(1, 0, 1, 0,     0,  0, 0,     0));
    tbl.push_back(mk(0, 0, 0, 1,  1234,  1, 0,     0));
    tbl.push_back(mk(0, 1, 0, 0,     0,  1, 0,  1234));
    tbl.push_back(mk(0, 1, 0, 0,     0,  1, 0,  1234));
    tbl.push_back(mk(0, 1, 0, 1,   -50,  1, 0,  1234));
    tbl.push_back(mk(0, 1, 0, 0,     0,  1, 0,  1234));
    tbl.push_back(mk(0, 1, 0, 0,     0,  1, 0,   -50));
    tbl.push_back(mk(0, 1, 1, 0,     0,  1, 0,   913));
    tbl.push_back(mk(0, 1, 1, 0,     0,  1, 0,   592));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst_a       = tbl[i].rst;
      a_if.CE     = tbl[i].ce;
      a_if.ENABLE = tbl[i].en;
      a_if.IVALID = tbl[i].vld;
      a_if.IDATA  = 16'(tbl[i].din);
      #1;
      check($sformatf("row%0d_iready", i), int'(a_if.IREADY), int'(tbl[i].exp_rdy));
      if (tbl[i].ce) exp_q.push_back(tbl[i].exp_od);
      @(posedge clk);
      #1;
      check($sformatf("row%0d_uflow", i), int'(a_if.UFLOW), int'(tbl[i].exp_uf));
      if (tbl[i].rst) begin
        check($sformatf("row%0d_reset_odata", i), int'(a_if.ODATA), tbl[i].exp_od);
        check($sformatf("row%0d_reset_ostb", i), int'(a_if.OSTB), 0);
      end
    end

    @(negedge clk);
    a_if.CE = 1'b0;
    a_if.IVALID = 1'b0;
    repeat (3) @(negedge clk);
    check("a_scoreboard_drained", exp_q.size(), 0);

    // RATIO=72 instance: ramp 0 -> 7200 -> -7200, then an underflowing boundary.
    @(negedge clk);
    #1;
    check("b_iready_in_reset", int'(b_if.IREADY), 0);
    rst_b = 1'b0;
    b_if.IVALID = 1'b1;
    b_if.IDATA  = 16'sd7200;
    #1;
    check("b_iready_after_reset", int'(b_if.IREADY), 1);
    @(negedge clk);
    b_if.IDATA = -16'sd7200;
    @(negedge clk);
    b_if.IVALID = 1'b0;
    #1;
    check("b_iready_full", int'(b_if.IREADY), 0);
    b_if.CE = 1'b1;
    b_if.ENABLE = 1'b1;
    for (int k = 0; k < 145; k++) begin
      @(posedge clk);
      #1;
      od = int'(b_if.ODATA);
      case (k)
        0: begin
          check("b_k0_odata", od, 0);
          check("b_k0_ostb", int'(b_if.OSTB), 1);
          check("b_k0_uflow", int'(b_if.UFLOW), 0);
        end
        1:   check("b_k1_odata", od, 99);
        71:  check("b_k71_odata", od, 7098);
        72:  check("b_k72_odata", od, 7200);
        73:  check("b_k73_odata", od, 7000);
        143: check("b_k143_odata_floor", od, -6997);
        144: begin
          check("b_k144_odata", od, -7200);
          check("b_k144_uflow", int'(b_if.UFLOW), 1);
        end
        default: ;
      endcase
    end
    @(negedge clk);
    b_if.CE = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
